// File: rtl/cache_ctrl_pkg.sv
// Shared types and address-field geometry for the data cache controller.
// Build option CACHE_STATS_EN adds the load hit/miss counters.
package cache_ctrl_pkg;

  localparam int INDEX_COUNT = 256;
  localparam int DATA_W = 11;
  localparam int TAG_W = 20;
  localparam int IDX_W = $clog2(INDEX_COUNT);
  localparam int ADDR_W = TAG_W + IDX_W;
  localparam int LINE_W = TAG_W + DATA_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    COMPARE,
    MEM_REQ,
    MEM_WAIT,
    FILL,
    WT_REQ,
    RESP
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } line_t;

  function automatic logic [IDX_W-1:0] addr_idx(
    input logic [ADDR_W-1:0] a
  );
    return a[IDX_W-1:0];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(
    input logic [ADDR_W-1:0] a
  );
    return a[ADDR_W-1:IDX_W];
  endfunction

endpackage

// File: rtl/cache_controller_if.sv
// CPU, memory-bus and array signals of the cache controller.
// slave = controller side, master = CPU/memory/array side.
interface cache_controller_if;
  import cache_ctrl_pkg::*;

  logic              cpu_req_valid;
  logic              cpu_req_ready;
  logic              cpu_req_we;
  logic [ADDR_W-1:0] cpu_req_addr;
  logic [DATA_W-1:0] cpu_req_wdata;
  logic              cpu_flush;
  logic              cpu_resp_valid;
  logic              cpu_resp_ready;
  logic [DATA_W-1:0] cpu_resp_rdata;

  logic              arr_enable;
  logic              arr_rd_wr_sel;
  logic [IDX_W-1:0]  arr_index_sel;
  logic [LINE_W-1:0] arr_write_index;
  logic [DATA_W-1:0] arr_read_data;
  logic [TAG_W-1:0]  arr_cache_tag;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_rdata;

  modport slave (
    input  cpu_req_valid, cpu_req_we,
    input  cpu_req_addr, cpu_req_wdata,
    input  cpu_flush, cpu_resp_ready,
    output cpu_req_ready, cpu_resp_valid,
    output cpu_resp_rdata,
    output arr_enable, arr_rd_wr_sel,
    output arr_index_sel, arr_write_index,
    input  arr_read_data, arr_cache_tag,
    output mem_req_valid, mem_req_we,
    output mem_req_addr, mem_req_wdata,
    input  mem_req_ready,
    input  mem_resp_valid, mem_resp_rdata
  );

  modport master (
    output cpu_req_valid, cpu_req_we,
    output cpu_req_addr, cpu_req_wdata,
    output cpu_flush, cpu_resp_ready,
    input  cpu_req_ready, cpu_resp_valid,
    input  cpu_resp_rdata,
    input  arr_enable, arr_rd_wr_sel,
    input  arr_index_sel, arr_write_index,
    output arr_read_data, arr_cache_tag,
    input  mem_req_valid, mem_req_we,
    input  mem_req_addr, mem_req_wdata,
    output mem_req_ready,
    output mem_resp_valid, mem_resp_rdata
  );

endinterface

// File: rtl/cache_stats.sv
// Saturating load hit/miss counters.
// Only compiled when CACHE_STATS_EN is defined.
`ifdef CACHE_STATS_EN
module cache_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        hit_inc,
  input  logic        miss_inc,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  logic [31:0] hit_q, hit_d;
  logic [31:0] miss_q, miss_d;

  always_comb begin
    hit_d = hit_q;
    miss_d = miss_q;
    if (hit_inc && hit_q != '1)
      hit_d = hit_q + 32'd1;
    if (miss_inc && miss_q != '1)
      miss_d = miss_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_q <= '0;
      miss_q <= '0;
    end else begin
      hit_q <= hit_d;
      miss_q <= miss_d;
    end
  end

  assign hit_count = hit_q;
  assign miss_count = miss_q;

endmodule
`endif

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache sequencer.
// Define CACHE_STATS_EN to add hit_count/miss_count outputs.
module cache_controller
  import cache_ctrl_pkg::*;
(
  input logic clk,
  input logic rst,
  cache_controller_if.slave bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  state_t state_q, state_d;
  logic we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [INDEX_COUNT-1:0] valid_q, valid_d;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic hit;
  logic ready;
  line_t wr_line;

  assign idx = addr_idx(addr_q);
  assign tag = addr_tag(addr_q);
  // the array tag follows index_sel combinationally
  assign hit = valid_q[idx] && (bus.arr_cache_tag == tag);
  assign bus.cpu_req_ready = ready && rst;
  assign bus.arr_write_index = wr_line;

  always_comb begin
    state_d = state_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    valid_d = valid_q;
    ready = 1'b0;
    wr_line = '0;
    bus.cpu_resp_valid = 1'b0;
    bus.cpu_resp_rdata = '0;
    bus.arr_enable = 1'b0;
    bus.arr_rd_wr_sel = 1'b0;
    bus.arr_index_sel = '0;
    bus.mem_req_valid = 1'b0;
    bus.mem_req_we = 1'b0;
    bus.mem_req_addr = '0;
    bus.mem_req_wdata = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.cpu_flush) begin
          valid_d = '0;
        end else begin
          ready = 1'b1;
          if (bus.cpu_req_valid) begin
            we_d = bus.cpu_req_we;
            addr_d = bus.cpu_req_addr;
            wdata_d = bus.cpu_req_wdata;
            state_d = LOOKUP;
          end
        end
      end
      LOOKUP: begin
        bus.arr_enable = 1'b1;
        bus.arr_index_sel = idx;
        state_d = COMPARE;
      end
      COMPARE: begin
        bus.arr_index_sel = idx;
        if (we_q) begin
          rdata_d = '0;
          state_d = WT_REQ;
          if (hit) begin
            bus.arr_enable = 1'b1;
            bus.arr_rd_wr_sel = 1'b1;
            wr_line = '{valid: 1'b1, tag: tag, data: wdata_q};
          end
        end else if (hit) begin
          rdata_d = bus.arr_read_data;
          state_d = RESP;
        end else begin
          state_d = MEM_REQ;
        end
      end
      MEM_REQ: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_addr = addr_q;
        if (bus.mem_req_ready)
          state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (bus.mem_resp_valid) begin
          rdata_d = bus.mem_resp_rdata;
          state_d = FILL;
        end
      end
      FILL: begin
        bus.arr_enable = 1'b1;
        bus.arr_rd_wr_sel = 1'b1;
        bus.arr_index_sel = idx;
        wr_line = '{valid: 1'b1, tag: tag, data: rdata_q};
        valid_d[idx] = 1'b1;
        state_d = RESP;
      end
      WT_REQ: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_we = 1'b1;
        bus.mem_req_addr = addr_q;
        bus.mem_req_wdata = wdata_q;
        if (bus.mem_req_ready)
          state_d = RESP;
      end
      RESP: begin
        bus.cpu_resp_valid = 1'b1;
        bus.cpu_resp_rdata = rdata_q;
        if (bus.cpu_resp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
    end
  end

`ifdef CACHE_STATS_EN
  logic hit_inc;
  logic miss_inc;

  assign hit_inc = (state_q == COMPARE) && !we_q && hit;
  assign miss_inc = (state_q == COMPARE) && !we_q && !hit;

  cache_stats u_stats (
    .clk        (clk),
    .rst        (rst),
    .hit_inc    (hit_inc),
    .miss_inc   (miss_inc),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );
`endif

endmodule
